// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// The master (MEM stage) issues requests; the slave (memory) returns data and ack.
interface mem_stage_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: runs the data-memory access, resolves the branch and drives MEM/WB.
// Optional watchdog on outstanding accesses is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemToReg,
    input  logic                  RegWrite,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  Branch,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic [DATA_WIDTH-1:0] pr_read_data2,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic                  PCSrc,
    output logic [DATA_WIDTH-1:0] pc_branch_target,
    output logic                  mem_stall,
    mem_stage_ctrl_if.master      dmem,
    output logic                  MemToReg_out,
    output logic                  RegWrite_out,
    output logic [DATA_WIDTH-1:0] read_data_out,
    output logic [DATA_WIDTH-1:0] alu_result_out,
    output logic [4:0]            write_reg_out,
    output logic                  mem_error
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, next_state;
    logic   mem_op;
    logic   rd_done;
    logic   timeout_hit;

    logic                  mem_to_reg_p1;
    logic                  reg_write_p1;
    logic [DATA_WIDTH-1:0] read_data_p1;
    logic [DATA_WIDTH-1:0] alu_result_p1;
    logic [4:0]            write_reg_p1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign mem_op           = MemRead | MemWrite;
    assign PCSrc            = Branch & alu_zero;
    assign pc_branch_target = branch_target;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             at_limit;

    // The WAIT cycle whose missing ack would bring the count to the limit is the last one.
    assign at_limit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state       = state;
        dmem.dmem_req    = 1'b0;
        dmem.dmem_we     = 1'b0;
        dmem.dmem_addr   = '0;
        dmem.dmem_wdata  = '0;
        mem_stall        = 1'b0;
        rd_done          = 1'b0;
        timeout_hit      = 1'b0;
        case (state)
            IDLE: begin
                // Ack is not looked at here: an access always spends at least one WAIT cycle.
                if (mem_op) begin
                    dmem.dmem_req   = 1'b1;
                    dmem.dmem_we    = MemWrite;
                    dmem.dmem_addr  = alu_result;
                    dmem.dmem_wdata = pr_read_data2;
                    mem_stall       = 1'b1;
                    next_state      = WAIT;
                end
            end
            WAIT: begin
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = MemWrite;
                dmem.dmem_addr  = alu_result;
                dmem.dmem_wdata = pr_read_data2;
                if (dmem.dmem_ack) begin
                    rd_done    = MemRead & ~MemWrite;
                    next_state = IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (at_limit) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                end
`endif
                else begin
                    mem_stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) wait_cnt <= '0;
        else if (!dmem.dmem_ack)    wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)            mem_error <= 1'b0;
        else if (timeout_hit) mem_error <= 1'b1;
    end
`else
    assign mem_error = 1'b0;
`endif

    // MEM/WB boundary: a stall inserts a bubble by clearing the write-back controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_to_reg_p1 <= 1'b0;
            reg_write_p1  <= 1'b0;
            read_data_p1  <= '0;
            alu_result_p1 <= '0;
            write_reg_p1  <= '0;
        end else if (mem_stall) begin
            mem_to_reg_p1 <= 1'b0;
            reg_write_p1  <= 1'b0;
        end else begin
            mem_to_reg_p1 <= MemToReg;
            reg_write_p1  <= RegWrite;
            read_data_p1  <= rd_done ? dmem.dmem_rdata : '0;
            alu_result_p1 <= alu_result;
            write_reg_p1  <= write_reg;
        end
    end

    assign MemToReg_out   = mem_to_reg_p1;
    assign RegWrite_out   = reg_write_p1;
    assign read_data_out  = read_data_p1;
    assign alu_result_out = alu_result_p1;
    assign write_reg_out  = write_reg_p1;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: upstream pipeline and memory responder driven per instruction,
// results compared against an instruction-level model of stall length and MEM/WB contents.
module tb_mem_stage_ctrl;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct packed {
        logic          mtr;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          br;
        logic          zero;
        logic [DW-1:0] alu;
        logic [DW-1:0] wdata;
        logic [DW-1:0] tgt;
        logic [4:0]    wr;
    } instr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemToReg, RegWrite, MemRead, MemWrite, Branch, alu_zero;
    logic [DW-1:0] alu_result, pr_read_data2, branch_target;
    logic [4:0]    write_reg;
    logic          PCSrc, mem_stall;
    logic [DW-1:0] pc_branch_target;
    logic          MemToReg_out, RegWrite_out, mem_error;
    logic [DW-1:0] read_data_out, alu_result_out;
    logic [4:0]    write_reg_out;

    mem_stage_ctrl_if #(.DATA_WIDTH(DW)) dmem ();

    mem_stage_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .alu_result(alu_result), .alu_zero(alu_zero),
        .pr_read_data2(pr_read_data2), .write_reg(write_reg), .branch_target(branch_target),
        .PCSrc(PCSrc), .pc_branch_target(pc_branch_target), .mem_stall(mem_stall),
        .dmem(dmem),
        .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out),
        .write_reg_out(write_reg_out), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected MEM/WB contents after the most recent retirement
    logic [DW-1:0] m_alu, m_rd;
    logic [4:0]    m_wr;
    logic          m_err;

    task automatic apply(input instr_t in);
        MemToReg = in.mtr; RegWrite = in.rw; MemRead = in.mr; MemWrite = in.mw;
        Branch = in.br; alu_zero = in.zero; alu_result = in.alu;
        pr_read_data2 = in.wdata; branch_target = in.tgt; write_reg = in.wr;
    endtask

    function automatic instr_t nop_instr();
        instr_t n;
        n = '0;
        return n;
    endfunction

    function automatic instr_t rand_instr();
        instr_t n;
        n = '0;
        n.alu = $urandom; n.wdata = $urandom; n.tgt = $urandom;
        n.wr = 5'($urandom_range(0, 31)); n.zero = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: begin n.rw = 1'b1; end
            1: begin n.mr = 1'b1; n.rw = 1'b1; n.mtr = 1'b1; end
            2: begin n.mw = 1'b1; end
            3: begin n.mr = 1'b1; n.mw = 1'b1; n.rw = 1'($urandom_range(0, 1)); n.mtr = 1'($urandom_range(0, 1)); end
            default: begin n.br = 1'b1; end
        endcase
        return n;
    endfunction

    // Presents one instruction until it leaves the stage. Memory acks in WAIT cycle `lat`
    // (or never, when `tmo` is set); the instruction occupies lat+1 cycles, 1 if no memory op.
    task automatic run_instr(input instr_t in, input int lat, input logic [DW-1:0] rd,
                             input bit tmo, output int req_cyc, output int stall_cyc);
        bit mop, exp_stall, done;
        int cyc;
        logic [DW-1:0] exp_rd;
        mop = in.mr | in.mw;
        req_cyc = 0; stall_cyc = 0; cyc = 0; done = 0;
        apply(in);
        while (!done) begin
            if (mop && cyc == lat && !tmo) begin dmem.dmem_ack = 1'b1; dmem.dmem_rdata = rd; end
            else begin
                dmem.dmem_ack = (cyc == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                dmem.dmem_rdata = $urandom;
            end
            exp_stall = mop && (cyc < lat);
            @(negedge clk);
            if (dmem.dmem_req) req_cyc++;
            if (mem_stall) stall_cyc++;
            total++; if (PCSrc !== (in.br & in.zero)) begin bad++; $display("FAIL pcsrc: got %b want %b", PCSrc, in.br & in.zero); end
            total++; if (pc_branch_target !== in.tgt) begin bad++; $display("FAIL pc_target: got %h want %h", pc_branch_target, in.tgt); end
            total++; if (dmem.dmem_req !== mop) begin bad++; $display("FAIL dmem_req: got %b want %b cyc %0d", dmem.dmem_req, mop, cyc); end
            total++; if (mem_stall !== exp_stall) begin bad++; $display("FAIL mem_stall: got %b want %b cyc %0d", mem_stall, exp_stall, cyc); end
            if (mop) begin
                total++; if (dmem.dmem_addr !== in.alu) begin bad++; $display("FAIL dmem_addr: got %h want %h", dmem.dmem_addr, in.alu); end
                total++; if (dmem.dmem_we !== in.mw) begin bad++; $display("FAIL dmem_we: got %b want %b", dmem.dmem_we, in.mw); end
                total++; if (dmem.dmem_wdata !== in.wdata) begin bad++; $display("FAIL dmem_wdata: got %h want %h", dmem.dmem_wdata, in.wdata); end
            end
            @(posedge clk); #1;
            if (exp_stall) begin
                total++; if (RegWrite_out !== 1'b0 || MemToReg_out !== 1'b0) begin bad++; $display("FAIL bubble_ctrl: got rw=%b mtr=%b want 0 0", RegWrite_out, MemToReg_out); end
                total++; if (alu_result_out !== m_alu || write_reg_out !== m_wr || read_data_out !== m_rd) begin
                    bad++; $display("FAIL bubble_hold: got %h/%0d/%h want %h/%0d/%h", alu_result_out, write_reg_out, read_data_out, m_alu, m_wr, m_rd); end
            end else begin
                exp_rd = (in.mr && !in.mw && !tmo) ? rd : '0;
                m_alu = in.alu; m_wr = in.wr; m_rd = exp_rd;
                if (tmo && mop) m_err = 1'b1;
                total++; if (RegWrite_out !== in.rw) begin bad++; $display("FAIL wb_regwrite: got %b want %b", RegWrite_out, in.rw); end
                total++; if (MemToReg_out !== in.mtr) begin bad++; $display("FAIL wb_memtoreg: got %b want %b", MemToReg_out, in.mtr); end
                total++; if (alu_result_out !== m_alu) begin bad++; $display("FAIL wb_alu: got %h want %h", alu_result_out, m_alu); end
                total++; if (write_reg_out !== m_wr) begin bad++; $display("FAIL wb_wreg: got %0d want %0d", write_reg_out, m_wr); end
                total++; if (read_data_out !== m_rd) begin bad++; $display("FAIL wb_rdata: got %h want %h", read_data_out, m_rd); end
                total++; if (mem_error !== m_err) begin bad++; $display("FAIL mem_error: got %b want %b", mem_error, m_err); end
                done = 1;
            end
            cyc++;
        end
        dmem.dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        apply(nop_instr());
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_alu = '0; m_wr = '0; m_rd = '0; m_err = 1'b0;
        total++; if ({RegWrite_out, MemToReg_out, alu_result_out, write_reg_out, read_data_out} !== '0) begin
            bad++; $display("FAIL reset_wb: got rw=%b mtr=%b alu=%h wr=%0d rd=%h want all 0", RegWrite_out, MemToReg_out, alu_result_out, write_reg_out, read_data_out); end
        total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", mem_error); end
        @(negedge clk);
        total++; if (dmem.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL reset_idle: got req=%b stall=%b want 0 0", dmem.dmem_req, mem_stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        instr_t in; int rq, st;
        in = '0; in.rw = 1'b1; in.alu = 32'h1234; in.wr = 5'd5;
        run_instr(in, 0, '0, 1'b0, rq, st);
        total++; if (st !== 0) begin bad++; $display("FAIL alu_stall: got %0d want 0", st); end
    endtask

    task automatic test_load();
        instr_t in; int rq, st;
        in = '0; in.mr = 1'b1; in.rw = 1'b1; in.mtr = 1'b1; in.alu = 32'h40; in.wr = 5'd9;
        run_instr(in, 3, 32'hDEADBEEF, 1'b0, rq, st);
        total++; if (rq !== 4) begin bad++; $display("FAIL load_req_cycles: got %0d want 4", rq); end
        total++; if (st !== 3) begin bad++; $display("FAIL load_stall_cycles: got %0d want 3", st); end
    endtask

    task automatic test_back_to_back();
        instr_t st_i, ld_i; int rq, st;
        st_i = '0; st_i.mw = 1'b1; st_i.alu = 32'h80; st_i.wdata = 32'hCAFEF00D; st_i.wr = 5'd3;
        ld_i = '0; ld_i.mr = 1'b1; ld_i.rw = 1'b1; ld_i.mtr = 1'b1; ld_i.alu = 32'h84; ld_i.wr = 5'd7;
        run_instr(st_i, 1, 32'h0BAD0BAD, 1'b0, rq, st);
        total++; if (rq !== 2) begin bad++; $display("FAIL store_req_cycles: got %0d want 2", rq); end
        run_instr(ld_i, 2, 32'h13572468, 1'b0, rq, st);
        total++; if (rq !== 3) begin bad++; $display("FAIL b2b_load_req_cycles: got %0d want 3", rq); end
    endtask

    task automatic test_branch();
        instr_t in; int rq, st;
        in = '0; in.br = 1'b1; in.zero = 1'b1; in.tgt = 32'h200;
        apply(in);
        #1;
        total++; if (PCSrc !== 1'b1 || pc_branch_target !== 32'h200) begin bad++; $display("FAIL branch_taken: got %b/%h want 1/00000200", PCSrc, pc_branch_target); end
        alu_zero = 1'b0;
        #1;
        total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL branch_not_taken: got %b want 0", PCSrc); end
        in.zero = 1'b0;
        run_instr(in, 0, '0, 1'b0, rq, st);
    endtask

    task automatic test_random();
        instr_t in; int rq, st, lat;
        for (int i = 0; i < 200; i++) begin
            in = rand_instr();
            lat = $urandom_range(1, 5);
            run_instr(in, lat, $urandom, 1'b0, rq, st);
            if (in.mr | in.mw) begin
                total++; if (rq !== lat + 1) begin bad++; $display("FAIL rand_req_cycles: got %0d want %0d", rq, lat + 1); end
            end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        instr_t in; int rq, st;
        in = '0; in.mr = 1'b1; in.rw = 1'b1; in.mtr = 1'b1; in.alu = 32'h100; in.wr = 5'd4;
        run_instr(in, TO, 32'hFFFFFFFF, 1'b1, rq, st);
        total++; if (st !== TO) begin bad++; $display("FAIL timeout_stall: got %0d want %0d", st, TO); end
        in = '0; in.rw = 1'b1; in.alu = 32'h55;
        run_instr(in, 0, '0, 1'b0, rq, st);
    endtask
`endif

    task automatic test_reset_mid_access();
        instr_t pre, ld;
        pre = '0; pre.rw = 1'b1; pre.alu = 32'hA5A5A5A5; pre.wr = 5'd12;
        ld = '0; ld.mr = 1'b1; ld.rw = 1'b1; ld.mtr = 1'b1; ld.alu = 32'h300; ld.wr = 5'd2;
        begin
            int rq, st;
            run_instr(pre, 0, '0, 1'b0, rq, st);
        end
        apply(ld); dmem.dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        apply(nop_instr());
        m_alu = '0; m_wr = '0; m_rd = '0; m_err = 1'b0;
        total++; if ({RegWrite_out, MemToReg_out, alu_result_out, write_reg_out, read_data_out} !== '0) begin
            bad++; $display("FAIL midreset_wb: got rw=%b mtr=%b alu=%h wr=%0d rd=%h want all 0", RegWrite_out, MemToReg_out, alu_result_out, write_reg_out, read_data_out); end
        total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL midreset_err: got %b want 0", mem_error); end
        @(negedge clk);
        total++; if (dmem.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL midreset_idle: got req=%b stall=%b want 0 0", dmem.dmem_req, mem_stall); end
        @(posedge clk); #1;
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h77777777;
        @(negedge clk);
        total++; if (dmem.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL late_ack_idle: got req=%b stall=%b want 0 0", dmem.dmem_req, mem_stall); end
        @(posedge clk); #1;
        dmem.dmem_ack = 1'b0;
        total++; if (read_data_out !== '0 || RegWrite_out !== 1'b0) begin bad++; $display("FAIL late_ack_wb: got rd=%h rw=%b want 0 0", read_data_out, RegWrite_out); end
        begin
            int rq, st;
            run_instr(ld, 2, 32'h24681357, 1'b0, rq, st);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_branch();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register. Takes its control and data outputs, runs the data-memory access over a req/ack handshake and resolves the branch.
- Drives the MEM/WB pipeline register. Stalls upstream stages while a memory access is outstanding.
- Sits between the EX/MEM register and the write-back stage.

Parameters:
- DATA_WIDTH, 32, width of data, address and branch target buses.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- MemToReg  input  1  from EX/MEM register; selects memory data for write-back.
- RegWrite  input  1  from EX/MEM register; instruction writes the register file.
- MemRead  input  1  from EX/MEM register; load.
- MemWrite  input  1  from EX/MEM register; store.
- Branch  input  1  from EX/MEM register; branch instruction.
- alu_result  input  DATA_WIDTH  memory address, or write-back value.
- alu_zero  input  1  ALU zero flag.
- pr_read_data2  input  DATA_WIDTH  store data.
- write_reg  input  5  destination register.
- branch_target  input  DATA_WIDTH  branch target address.
- PCSrc  output  1  branch taken.
- pc_branch_target  output  DATA_WIDTH  equals branch_target.
- mem_stall  output  1  holds PC, IF/ID, ID/EX and EX/MEM registers.
- dmem_req  output  1  memory request.
- dmem_we  output  1  1 = write, 0 = read.
- dmem_addr  output  DATA_WIDTH  memory address.
- dmem_wdata  output  DATA_WIDTH  store data.
- dmem_rdata  input  DATA_WIDTH  load data; valid only with dmem_ack.
- dmem_ack  input  1  access complete.
- MemToReg_out  output  1  MEM/WB register.
- RegWrite_out  output  1  MEM/WB register.
- read_data_out  output  DATA_WIDTH  MEM/WB register.
- alu_result_out  output  DATA_WIDTH  MEM/WB register.
- write_reg_out  output  5  MEM/WB register.
- mem_error  output  1  sticky timeout flag; stays 0 without MEM_TIMEOUT_EN.

Behaviour:
- Branch path (combinational, no latency):
  - PCSrc = Branch & alu_zero.
  - pc_branch_target = branch_target.
- FSM states: IDLE, WAIT.
  - mem_op = MemRead | MemWrite.
- IDLE:
  - dmem_req = mem_op.
  - When mem_op = 1: dmem_we = MemWrite, dmem_addr = alu_result, dmem_wdata = pr_read_data2, next state WAIT.
  - dmem_ack is ignored in IDLE, so the minimum access time is 2 cycles.
- WAIT:
  - dmem_req stays 1; dmem_we, dmem_addr and dmem_wdata are driven from the EX/MEM inputs, which stay stable because upstream is stalled.
  - On dmem_ack = 1: next state IDLE.
- Stall:
  - mem_stall = (IDLE & mem_op) | (WAIT & ~dmem_ack).
  - mem_stall is combinational.
  - EX/MEM advances on the edge where dmem_ack is seen, so each access is issued exactly once.
- MEM/WB register update, on each clock edge:
  - mem_stall = 0: capture MemToReg, RegWrite, alu_result and write_reg. read_data_out <= dmem_rdata for a read completing in WAIT, otherwise 0.
  - mem_stall = 1: insert a bubble. RegWrite_out <= 0 and MemToReg_out <= 0; the data fields hold their values.
- Non-memory instructions pass through in 1 cycle with no stall.
- MemRead and MemWrite both 1: the access is a write (dmem_we = 1) and read_data_out <= 0.
- A memory op immediately after an ack is seen in IDLE on the next cycle and starts a new request. There is no dead cycle beyond the IDLE issue cycle.
- Reset (synchronous, including mid-access):
  - FSM goes to IDLE and dmem_req = 0 from the next cycle. The outstanding access is abandoned; the memory side must tolerate this.
  - All MEM/WB outputs go to 0 and mem_error goes to 0.
  - mem_stall then follows the inputs.
- Timing assumption: dmem_ack and dmem_rdata are sampled registered and must meet setup at clk. The combinational path dmem_ack -> mem_stall -> upstream enables is intended.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments on every WAIT cycle without dmem_ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack, that cycle is treated as a completion:
    - mem_stall = 0 and the FSM returns to IDLE.
    - read_data_out <= 0; RegWrite_out still follows RegWrite.
    - mem_error <= 1 and stays set until reset.
  - An ack on the same cycle the limit is reached counts as a normal completion and mem_error is not set.
- Without the macro: no counter, WAIT holds indefinitely, and mem_error is tied to 0.

Test Plan:
- ALU op, RegWrite=1, alu_result=0x1234, write_reg=5, no mem op -> no stall; next edge: RegWrite_out=1, alu_result_out=0x1234, write_reg_out=5, read_data_out=0.
- Load from address 0x40, ack 3 cycles after req, rdata=0xDEADBEEF -> dmem_req high with addr 0x40 for 4 cycles; mem_stall high until the ack cycle; RegWrite_out=0 during stall cycles; after the ack edge, read_data_out=0xDEADBEEF and MemToReg_out=1.
- Store of 0xCAFEF00D to 0x80, ack next cycle, followed immediately by a load -> exactly one write request; the load request starts the cycle after the ack; RegWrite_out never pulses for the store.
- Branch=1, alu_zero=1, branch_target=0x200 -> PCSrc=1 and pc_branch_target=0x200 in the same cycle; alu_zero=0 -> PCSrc=0.
- Reset asserted in the second WAIT cycle of a load -> next cycle dmem_req=0, FSM in IDLE, all MEM/WB outputs 0; a later ack is ignored.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, load with no ack -> stall released at the timeout, mem_error=1, read_data_out=0; mem_error stays 1 until reset.
